// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: arbitrates memory freeze,
// EX redirect and load-use hazards, and keeps saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [2:0]       id_src1,
  input  logic [2:0]       id_src2,
  input  logic             id_src1_used,
  input  logic             id_src2_used,
  input  logic             ex_valid,
  input  logic [2:0]       ex_dest,
  input  logic             ex_wb_en,
  input  logic             ex_is_load,
  input  logic             redirect_ex,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_hold,
  output logic             id_ex_bubble,
  output logic             ex_mem_hold,
  output logic             mem_abort,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic       pend_redirect, pend_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       abort_nxt;
  logic       timeout, frozen, eff_redirect, load_use;
  logic       pc_hold_c, if_id_hold_c, if_id_flush_c;
  logic       id_ex_hold_c, id_ex_bubble_c, ex_mem_hold_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  always_comb begin
    state_nxt      = state;
    pend_nxt       = pend_redirect;
    wait_nxt       = wait_cnt;
    abort_nxt      = 1'b0;
    pc_hold_c      = 1'b0;
    if_id_hold_c   = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_hold_c   = 1'b0;
    id_ex_bubble_c = 1'b0;
    ex_mem_hold_c  = 1'b0;

    timeout      = (state == MEM_WAIT) && !mem_ready && (wait_cnt == TIMEOUT);
    frozen       = (state == RUN) ? (mem_req && !mem_ready) : (!mem_ready && !timeout);
    eff_redirect = redirect_ex || pend_redirect;
    load_use     = id_valid && ex_valid && ex_is_load && ex_wb_en &&
                   ((id_src1_used && (id_src1 == ex_dest)) ||
                    (id_src2_used && (id_src2 == ex_dest)));

    if (frozen) begin
      pc_hold       = 1'b0;
      pc_hold_c     = 1'b1;
      if_id_hold_c  = 1'b1;
      id_ex_hold_c  = 1'b1;
      ex_mem_hold_c = 1'b1;
      state_nxt     = MEM_WAIT;
      wait_nxt      = (state == RUN) ? 8'd1 : wait_cnt + 8'd1;
      // Redirects seen while frozen collapse into one pending flush.
      pend_nxt      = pend_redirect || redirect_ex;
    end else begin
      state_nxt = RUN;
      wait_nxt  = 8'd0;
      pend_nxt  = 1'b0;
      abort_nxt = timeout;
      if (eff_redirect) begin
        if_id_flush_c  = 1'b1;
        id_ex_bubble_c = 1'b1;
      end else if (load_use) begin
        pc_hold_c      = 1'b1;
        if_id_hold_c   = 1'b1;
        id_ex_bubble_c = 1'b1;
      end
    end

    // Controls are forced low for as long as reset is asserted.
    pc_hold      = reset && pc_hold_c;
    if_id_hold   = reset && if_id_hold_c;
    if_id_flush  = reset && if_id_flush_c;
    id_ex_hold   = reset && id_ex_hold_c;
    id_ex_bubble = reset && id_ex_bubble_c;
    ex_mem_hold  = reset && ex_mem_hold_c;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= RUN;
      pend_redirect <= 1'b0;
      wait_cnt      <= 8'd0;
      mem_abort     <= 1'b0;
      stall_cnt     <= '0;
      flush_cnt     <= '0;
    end else begin
      state         <= state_nxt;
      pend_redirect <= pend_nxt;
      wait_cnt      <= wait_nxt;
      mem_abort     <= abort_nxt;
      stall_cnt     <= sat_inc(stall_cnt, pc_hold);
      flush_cnt     <= sat_inc(flush_cnt, if_id_flush);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios followed by random
// traffic, all checked against a freeze-streak reference model.
module tb_pipe_hazard_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          id_valid, id_src1_used, id_src2_used;
  logic [2:0]    id_src1, id_src2, ex_dest;
  logic          ex_valid, ex_wb_en, ex_is_load, redirect_ex, mem_req, mem_ready;
  logic          pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_hold;
  logic          mem_abort;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: length of the current freeze streak, pending redirect,
  // counters as plain integers, and the abort expected after the last edge.
  int m_streak, m_stall, m_flush;
  bit m_pend, m_abort;
  bit e_pc, e_ifh, e_iff, e_idh, e_idb, e_exh, e_frozen, e_timeout, e_applied;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
    .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load),
    .redirect_ex(redirect_ex), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_hold(id_ex_hold), .id_ex_bubble(id_ex_bubble), .ex_mem_hold(ex_mem_hold),
    .mem_abort(mem_abort), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_streak = 0; m_pend = 0; m_stall = 0; m_flush = 0; m_abort = 0;
  endtask

  task automatic model_eval();
    bit in_wait, redir, lu;
    {e_pc, e_ifh, e_iff, e_idh, e_idb, e_exh} = '0;
    e_frozen = 0; e_timeout = 0; e_applied = 0;
    if (reset !== 1'b1) return;
    in_wait   = (m_streak > 0);
    e_timeout = in_wait && !mem_ready && (m_streak == TO);
    e_frozen  = in_wait ? (!mem_ready && !e_timeout) : (mem_req && !mem_ready);
    redir     = redirect_ex || m_pend;
    lu = id_valid && ex_valid && ex_is_load && ex_wb_en &&
         ((id_src1_used && id_src1 == ex_dest) || (id_src2_used && id_src2 == ex_dest));
    if (e_frozen) begin
      e_pc = 1; e_ifh = 1; e_idh = 1; e_exh = 1;
    end else if (redir) begin
      e_iff = 1; e_idb = 1; e_applied = 1;
    end else if (lu) begin
      e_pc = 1; e_ifh = 1; e_idb = 1;
    end
  endtask

  task automatic model_commit();
    m_abort = e_timeout;
    if (e_pc && m_stall < CMAX) m_stall++;
    if (e_applied && m_flush < CMAX) m_flush++;
    if (e_frozen) begin
      m_streak++;
      m_pend = m_pend || redirect_ex;
    end else begin
      m_streak = 0;
      m_pend   = 0;
    end
  endtask

  task automatic check_all();
    chk("pc_hold", pc_hold, e_pc);
    chk("if_id_hold", if_id_hold, e_ifh);
    chk("if_id_flush", if_id_flush, e_iff);
    chk("id_ex_hold", id_ex_hold, e_idh);
    chk("id_ex_bubble", id_ex_bubble, e_idb);
    chk("ex_mem_hold", ex_mem_hold, e_exh);
    chk("mem_abort", mem_abort, m_abort);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
  endtask

  // Inputs are set at the falling edge; checks run 1ns later, state advances at posedge.
  task automatic cycle();
    #1;
    model_eval();
    check_all();
    @(posedge clock);
    if (reset === 1'b1) model_commit();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_src1 = 0; id_src2 = 0; id_src1_used = 0; id_src2_used = 0;
    ex_valid = 0; ex_dest = 0; ex_wb_en = 0; ex_is_load = 0;
    redirect_ex = 0; mem_req = 0; mem_ready = 1;
  endtask

  task automatic set_load_use();
    ex_is_load = 1; ex_wb_en = 1; ex_valid = 1; ex_dest = 3;
    id_valid = 1; id_src2 = 3; id_src2_used = 1; id_src1 = 5; id_src1_used = 1;
  endtask

  task automatic do_reset();
    reset = 0;
    model_reset();
    cycle();
    reset = 1;
    clear_inputs();
  endtask

  initial begin
    reset = 0;
    clear_inputs();
    model_reset();
    @(negedge clock);
    // Reset state, with hazard inputs active to show outputs stay low.
    mem_req = 1; mem_ready = 0; redirect_ex = 1;
    cycle();
    cycle();
    reset = 1;
    clear_inputs();
    cycle();

    // Load-use stall, then the same with the matching source unused.
    set_load_use();
    cycle();
    clear_inputs();
    cycle();
    chk("lu_stall_cnt", stall_cnt, 1);
    set_load_use();
    id_src2_used = 0;
    cycle();
    clear_inputs();
    cycle();
    chk("lu_unused_stall_cnt", stall_cnt, 1);

    // Three-cycle memory wait.
    do_reset();
    mem_req = 1; mem_ready = 0;
    repeat (3) cycle();
    mem_ready = 1;
    cycle();
    mem_req = 0;
    cycle();
    chk("memwait_stall_cnt", stall_cnt, 3);

    // Redirect in the second frozen cycle, released two cycles later.
    do_reset();
    mem_req = 1; mem_ready = 0;
    cycle();
    redirect_ex = 1;
    cycle();
    redirect_ex = 0;
    cycle();
    mem_ready = 1;
    #1;
    chk("release_flush", if_id_flush, 1);
    chk("release_bubble", id_ex_bubble, 1);
    cycle();
    mem_req = 0;
    cycle();
    chk("frz_redirect_flush_cnt", flush_cnt, 1);

    // Redirect outranks load-use.
    do_reset();
    set_load_use();
    redirect_ex = 1;
    cycle();
    clear_inputs();
    cycle();
    chk("prio_stall_cnt", stall_cnt, 0);
    chk("prio_flush_cnt", flush_cnt, 1);

    // Timeout: memory never answers.
    do_reset();
    mem_req = 1; mem_ready = 0;
    repeat (TO) cycle();
    #1;
    chk("timeout_unfrozen", pc_hold, 0);
    cycle();
    chk("timeout_abort", mem_abort, 1);
    repeat (3) cycle();
    clear_inputs();
    cycle();

    // Asynchronous reset in the middle of a memory wait.
    do_reset();
    mem_req = 1; mem_ready = 0;
    repeat (2) cycle();
    #2;
    reset = 0;
    model_reset();
    #1;
    chk("async_rst_pc_hold", pc_hold, 0);
    chk("async_rst_stall_cnt", stall_cnt, 0);
    @(negedge clock);
    cycle();
    reset = 1;
    clear_inputs();
    repeat (2) cycle();

    // Stall counter saturation.
    do_reset();
    set_load_use();
    repeat (20) cycle();
    clear_inputs();
    cycle();
    chk("sat_stall_cnt", stall_cnt, CMAX);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        reset = 0;
        model_reset();
      end else begin
        reset = 1;
      end
      id_valid     = $urandom_range(0, 3) != 0;
      id_src1      = 3'($urandom_range(0, 3));
      id_src2      = 3'($urandom_range(0, 3));
      id_src1_used = $urandom_range(0, 1) == 1;
      id_src2_used = $urandom_range(0, 1) == 1;
      ex_valid     = $urandom_range(0, 3) != 0;
      ex_dest      = 3'($urandom_range(0, 3));
      ex_wb_en     = $urandom_range(0, 3) != 0;
      ex_is_load   = $urandom_range(0, 1) == 1;
      redirect_ex  = $urandom_range(0, 7) == 0;
      mem_req      = $urandom_range(0, 2) == 0;
      mem_ready    = $urandom_range(0, 2) != 0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
